// File: rtl/clk_ndiv_pkg.sv
// Shared types for the multi-channel clock divider: channel config, channel state, limits.
// Config fields carry a duty value only when CLK_NDIV_DUTY_EN is defined.
package clk_ndiv_pkg;

   localparam int CH_MAX = 16;
   // Config storage width; channel divisors of W <= CFG_W bits are zero-extended into it.
   localparam int CFG_W  = 64;

   typedef struct packed {
      logic [CFG_W-1:0] div;
`ifdef CLK_NDIV_DUTY_EN
      logic [CFG_W-1:0] duty;
`endif
   } chan_cfg_t;

   typedef enum logic [1:0] {
      CS_OFF,
      CS_IDLE,
      CS_RUN
   } chan_state_t;

   function automatic logic [CFG_W-1:0] DIV_MAX(input int w);
      return (CFG_W'(1) << w) - CFG_W'(1);
   endfunction

endpackage

// File: rtl/clk_ndiv_chan.sv
// One divider channel: counter, shadow/pending divisor, toggle (or duty) output and tick strobe.
// Optional duty-cycle output when CLK_NDIV_DUTY_EN is defined.
module clk_ndiv_chan
   import clk_ndiv_pkg::*;
#(
   parameter int          W       = 32,
   parameter int unsigned DEF_DIV = 2500000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         sync,
   input  logic         wr,
   input  logic [W-1:0] wr_div,
`ifdef CLK_NDIV_DUTY_EN
   input  logic [W-1:0] wr_duty,
`endif
   output logic         pend,
   output logic         clk_out,
   output logic         tick
);

   logic [W-1:0] count_reg, count_next;
   chan_cfg_t    act_reg, act_next;
   chan_cfg_t    shadow_reg, shadow_next;
   logic         pend_reg, pend_next;
   logic         clk_out_reg, clk_out_next;
   logic         tick_reg, tick_next;
   chan_state_t  state;
   logic         tc;
   logic         apply;

   always_comb begin
      state = CS_RUN;
      if (act_reg.div == '0)
         state = CS_OFF;
      else if (!en)
         state = CS_IDLE;

      tc = (state == CS_RUN) && (CFG_W'(count_reg) == act_reg.div - CFG_W'(1));
      // A stopped channel has no period to protect, so a pending divisor lands at once.
      apply = pend_reg && (sync || tc || (state != CS_RUN));

      act_next    = apply ? shadow_reg : act_reg;
      shadow_next = shadow_reg;
      pend_next   = pend_reg && !apply;
      if (wr) begin
         shadow_next.div = CFG_W'(wr_div);
`ifdef CLK_NDIV_DUTY_EN
         shadow_next.duty = CFG_W'(wr_duty);
`endif
         pend_next = 1'b1;
      end

      count_next   = '0;
      tick_next    = 1'b0;
      clk_out_next = 1'b0;
      if (!sync && (state == CS_RUN)) begin
         if (tc) begin
            tick_next = 1'b1;
`ifndef CLK_NDIV_DUTY_EN
            clk_out_next = !clk_out_reg;
`endif
         end else begin
            count_next = count_reg + W'(1);
`ifndef CLK_NDIV_DUTY_EN
            clk_out_next = clk_out_reg;
`endif
         end
`ifdef CLK_NDIV_DUTY_EN
         clk_out_next = (CFG_W'(count_next) < act_next.duty);
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg      <= '0;
         act_reg.div    <= CFG_W'(DEF_DIV);
         shadow_reg.div <= CFG_W'(DEF_DIV);
`ifdef CLK_NDIV_DUTY_EN
         act_reg.duty    <= CFG_W'(DEF_DIV >> 1);
         shadow_reg.duty <= CFG_W'(DEF_DIV >> 1);
`endif
         pend_reg    <= 1'b0;
         clk_out_reg <= 1'b0;
         tick_reg    <= 1'b0;
      end else begin
         count_reg   <= count_next;
         act_reg     <= act_next;
         shadow_reg  <= shadow_next;
         pend_reg    <= pend_next;
         clk_out_reg <= clk_out_next;
         tick_reg    <= tick_next;
      end
   end

   assign pend    = pend_reg;
   assign clk_out = clk_out_reg;
   assign tick    = tick_reg;

endmodule

// File: rtl/clk_ndiv_multi.sv
// CH-channel programmable clock-enable/divider with shadowed reload, phase sync and tick strobes.
// Define CLK_NDIV_DUTY_EN to add the cfg_duty port and duty-cycle outputs.
module clk_ndiv_multi
   import clk_ndiv_pkg::*;
#(
   parameter int          CH      = 4,
   parameter int          W       = 32,
   parameter int unsigned DEF_DIV = 2500000,
   localparam int         CHW     = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [CH-1:0]  en,
   input  logic           sync,
   input  logic           cfg_wr,
   input  logic [CHW-1:0] cfg_ch,
   input  logic [W-1:0]   cfg_div,
`ifdef CLK_NDIV_DUTY_EN
   input  logic [W-1:0]   cfg_duty,
`endif
   output logic [CH-1:0]  cfg_pend,
   output logic [CH-1:0]  clk_out,
   output logic [CH-1:0]  tick
);

   logic [CH-1:0] wr_sel;

   generate
      for (genvar gi = 0; gi < CH; gi++) begin : g_chan
         // Indices >= CH match no channel, so such writes are dropped.
         assign wr_sel[gi] = cfg_wr && (cfg_ch == CHW'(gi));

         clk_ndiv_chan #(
            .W       (W),
            .DEF_DIV (DEF_DIV)
         ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (en[gi]),
            .sync    (sync),
            .wr      (wr_sel[gi]),
            .wr_div  (cfg_div),
`ifdef CLK_NDIV_DUTY_EN
            .wr_duty (cfg_duty),
`endif
            .pend    (cfg_pend[gi]),
            .clk_out (clk_out[gi]),
            .tick    (tick[gi])
         );
      end
   endgenerate

endmodule
